pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Moore FSM that sequences the 32-bit program counter and the instruction-fetch path of the CPU datapath.
- Drives PC enable, increment and bus-out strobes, the MAR/MDR/IR load strobes and the memory read request.
- Accepts branch redirects and stall/halt requests from the execute control unit.
- Counts retired fetches and flags memory timeouts.

Parameters:
MEM_TIMEOUT, 15, max cycles in T1 waiting for mem_ready before fault (1..255)
COUNT_W, 16, width of fetch_count

Ports:
clock  in  1  system clock; all state updates on rising edge
clear  in  1  synchronous active-high reset; overrides every other input
run  in  1  start/continue fetching
stall  in  1  hold fetch in T0 (bus busy)
mem_ready  in  1  memory read data valid
exec_done  in  1  execute unit finished current instruction
branch_taken  in  1  qualifies exec_done; redirect PC to bus target
halt_req  in  1  qualifies exec_done; stop after current instruction
pc_out  out  1  PC drives bus
mar_in  out  1  MAR loads from bus
pc_enable  out  1  PC register enable
pc_inc  out  1  PC increment select (with pc_enable)
target_out  out  1  branch target drives bus
mem_read  out  1  memory read request
mdr_in  out  1  MDR loads from memory
mdr_out  out  1  MDR drives bus
ir_in  out  1  IR loads from bus
ir_valid  out  1  new instruction in IR this cycle
halted  out  1  in HALT state
fault  out  1  in FAULT state
state  out  3  current state code
fetch_count  out  COUNT_W  completed fetches, saturating

Behaviour:
- The clock port is named clock and the reset port is named clear. One clock. The reset is synchronous and active-high: clear=1 at a rising edge sets state=IDLE, fetch_count=0 and the timeout counter to 0. clear has priority over all other inputs in every state, including mid-fetch.
- All strobe outputs are decoded from state (Moore), so every strobe is 0 in IDLE and therefore 0 after reset. Each strobe asserts only in the state listed below.
- State codes: IDLE=0, T0=1, T1=2, T2=3, EXEC=4, BRANCH=5, HALT=6, FAULT=7.
- IDLE: all strobes 0. run=1 -> T0.
- T0:
  - If stall=1, all strobes are 0 and the FSM stays in T0.
  - Otherwise pc_out=mar_in=pc_enable=pc_inc=1 for exactly one cycle, then -> T1. The MAR captures the old PC and the PC increments by 1 in the same edge.
- T1:
  - mem_read=mdr_in=1 on every cycle spent in T1.
  - The timeout counter increments each cycle without mem_ready.
  - mem_ready=1 -> T2 and the timeout counter resets to 0.
  - The counter reaching MEM_TIMEOUT with mem_ready=0 -> FAULT. mem_ready on that same cycle wins and the next state is T2.
- T2:
  - mdr_out=ir_in=ir_valid=1 for one cycle, then -> EXEC.
  - fetch_count increments by 1 and saturates at all-ones (no wrap).
- EXEC: all strobes 0; wait for exec_done. When exec_done=1, priority is:
  1. branch_taken=1 -> BRANCH (halt_req is remembered in a 1-bit flag)
  2. halt_req=1 -> HALT
  3. run=0 -> IDLE
  4. otherwise -> T0
- BRANCH:
  - target_out=pc_enable=1 and pc_inc=0 for one cycle, so the PC loads the bus target.
  - Then -> HALT if the halt flag is set, else IDLE if run=0, else T0. The halt flag clears on leaving BRANCH.
- HALT: halted=1; exits only via clear.
- FAULT: fault=1; exits only via clear.
- Inputs with no listed effect in a state are ignored; run=0 mid-fetch does not abort the fetch.
- Fetch latency with no stall and mem_ready on the first T1 cycle: 3 cycles from T0 entry to ir_valid.
- pc_enable and pc_inc are never 1 together outside T0. target_out and pc_out are never both 1.

Test Plan:
- clear=1 for 2 cycles, then run=1 with mem_ready held 1 -> states 1,2,3; PC strobes asserted only in T0; ir_valid on cycle 3; fetch_count=1; then EXEC.
- mem_ready delayed 5 cycles in T1 -> mem_read=1 for 6 cycles, then T2; no fault. With mem_ready never asserted and MEM_TIMEOUT=15 -> fault=1, state=7 on the 16th T1 cycle; clear returns to IDLE.
- exec_done with branch_taken=1 -> one BRANCH cycle (pc_enable=1, pc_inc=0, target_out=1), then T0. Same cycle with halt_req=1 as well -> BRANCH, then HALT.
- stall=1 for 4 cycles on T0 entry -> no strobes for 4 cycles; the T0 strobes fire on the cycle stall drops. clear asserted mid-T1 -> next state IDLE, fetch_count=0.
- Loop 70000 fetches at COUNT_W=16 -> fetch_count saturates at 65535. run=0 at exec_done -> IDLE; run=1 again -> T0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-path sequencer: steps the PC through T0/T1/T2, hands off to execute,
// applies branch redirects, and reports halt, memory timeout and fetch count.
module pc_fetch_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               run,
  input  logic               stall,
  input  logic               mem_ready,
  input  logic               exec_done,
  input  logic               branch_taken,
  input  logic               halt_req,
  output logic               pc_out,
  output logic               mar_in,
  output logic               pc_enable,
  output logic               pc_inc,
  output logic               target_out,
  output logic               mem_read,
  output logic               mdr_in,
  output logic               mdr_out,
  output logic               ir_in,
  output logic               ir_valid,
  output logic               halted,
  output logic               fault,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StT0     = 3'd1,
    StT1     = 3'd2,
    StT2     = 3'd3,
    StExec   = 3'd4,
    StBranch = 3'd5,
    StHalt   = 3'd6,
    StFault  = 3'd7
  } state_e;

  // Last tolerated wait count; one more miss at this value is a fault.
  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  state_e             state_q;
  logic [7:0]         tcount_q;
  logic [COUNT_W-1:0] count_q;
  logic               halt_flag_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= StIdle;
      tcount_q    <= '0;
      count_q     <= '0;
      halt_flag_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) state_q <= StT0;
        end
        StT0: begin
          if (!stall) state_q <= StT1;
        end
        StT1: begin
          if (mem_ready) begin
            state_q  <= StT2;
            tcount_q <= '0;
          end else if (tcount_q == TimeoutLast) begin
            state_q <= StFault;
          end else begin
            tcount_q <= tcount_q + 8'd1;
          end
        end
        StT2: begin
          state_q <= StExec;
          if (count_q != '1) count_q <= count_q + COUNT_W'(1);
        end
        StExec: begin
          if (exec_done) begin
            if (branch_taken) begin
              state_q     <= StBranch;
              halt_flag_q <= halt_req;
            end else if (halt_req) begin
              state_q <= StHalt;
            end else if (!run) begin
              state_q <= StIdle;
            end else begin
              state_q <= StT0;
            end
          end
        end
        StBranch: begin
          halt_flag_q <= 1'b0;
          if (halt_flag_q)  state_q <= StHalt;
          else if (!run)    state_q <= StIdle;
          else              state_q <= StT0;
        end
        StHalt, StFault: ;
      endcase
    end
  end

  // Strobes decode from state; stall only masks the T0 bus transfer.
  always_comb begin
    pc_out     = 1'b0;
    mar_in     = 1'b0;
    pc_enable  = 1'b0;
    pc_inc     = 1'b0;
    target_out = 1'b0;
    mem_read   = 1'b0;
    mdr_in     = 1'b0;
    mdr_out    = 1'b0;
    ir_in      = 1'b0;
    ir_valid   = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    unique case (state_q)
      StT0: begin
        if (!stall) begin
          pc_out    = 1'b1;
          mar_in    = 1'b1;
          pc_enable = 1'b1;
          pc_inc    = 1'b1;
        end
      end
      StT1: begin
        mem_read = 1'b1;
        mdr_in   = 1'b1;
      end
      StT2: begin
        mdr_out  = 1'b1;
        ir_in    = 1'b1;
        ir_valid = 1'b1;
      end
      StBranch: begin
        target_out = 1'b1;
        pc_enable  = 1'b1;
      end
      StHalt:  halted = 1'b1;
      StFault: fault  = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized scoreboard bench for pc_fetch_ctrl: a fetch-level plan produces
// per-cycle stimulus and expected outputs; a monitor checks each cycle.
module tb_pc_fetch_ctrl;

  localparam int unsigned MT   = 15;
  localparam int unsigned CW   = 8;
  localparam int          CMAX = (1 << CW) - 1;

  localparam logic [11:0] SNone  = 12'h000;
  localparam logic [11:0] ST0    = 12'hF00;
  localparam logic [11:0] ST1    = 12'h060;
  localparam logic [11:0] ST2    = 12'h01C;
  localparam logic [11:0] SBr    = 12'h280;
  localparam logic [11:0] SHalt  = 12'h002;
  localparam logic [11:0] SFault = 12'h001;

  logic clock = 1'b0;
  logic clear = 1'b1, run = 1'b0, stall = 1'b0, mem_ready = 1'b0;
  logic exec_done = 1'b0, branch_taken = 1'b0, halt_req = 1'b0;
  logic pc_out, mar_in, pc_enable, pc_inc, target_out, mem_read, mdr_in, mdr_out;
  logic ir_in, ir_valid, halted, fault;
  logic [2:0]    state;
  logic [CW-1:0] fetch_count;

  pc_fetch_ctrl #(.MEM_TIMEOUT(MT), .COUNT_W(CW)) dut (
    .clock(clock), .clear(clear), .run(run), .stall(stall), .mem_ready(mem_ready),
    .exec_done(exec_done), .branch_taken(branch_taken), .halt_req(halt_req),
    .pc_out(pc_out), .mar_in(mar_in), .pc_enable(pc_enable), .pc_inc(pc_inc),
    .target_out(target_out), .mem_read(mem_read), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .ir_in(ir_in), .ir_valid(ir_valid), .halted(halted), .fault(fault),
    .state(state), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic clear, run, stall, mem_ready, exec_done, branch_taken, halt_req;
  } in_t;

  typedef struct packed {
    logic          chk;
    logic [2:0]    st;
    logic [11:0]   strb;
    logic [CW-1:0] cnt;
  } exp_t;

  in_t  in_q[$];
  exp_t plan_q[$];
  exp_t sb_q[$];
  int   n_fetch = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic stuck = 1'b0;

  function automatic in_t noise();
    logic [6:0] b;
    in_t r;
    b = 7'($urandom);
    r = b;
    r.clear = 1'b0;
    return r;
  endfunction

  task automatic emit(input in_t i, input bit chk, input int st, input logic [11:0] s);
    exp_t e;
    e.chk  = chk;
    e.st   = 3'(st);
    e.strb = s;
    e.cnt  = CW'((n_fetch > CMAX) ? CMAX : n_fetch);
    in_q.push_back(i);
    plan_q.push_back(e);
  endtask

  task automatic go_idle_to_t0(input int k);
    in_t i;
    for (int j = 0; j < k; j++) begin
      i = noise(); i.run = 1'b0; emit(i, 1, 0, SNone);
    end
    i = noise(); i.run = 1'b1; emit(i, 1, 0, SNone);
  endtask

  // delay = T1 cycles without mem_ready; delay >= MT ends in fault.
  task automatic fetch(input int stalls, input int delay);
    in_t i;
    for (int j = 0; j < stalls; j++) begin
      i = noise(); i.stall = 1'b1; emit(i, 1, 1, SNone);
    end
    i = noise(); i.stall = 1'b0; emit(i, 1, 1, ST0);
    if (delay >= int'(MT)) begin
      for (int j = 0; j < int'(MT); j++) begin
        i = noise(); i.mem_ready = 1'b0; emit(i, 1, 2, ST1);
      end
    end else begin
      for (int j = 0; j < delay; j++) begin
        i = noise(); i.mem_ready = 1'b0; emit(i, 1, 2, ST1);
      end
      i = noise(); i.mem_ready = 1'b1; emit(i, 1, 2, ST1);
      i = noise(); emit(i, 1, 3, ST2);
      n_fetch++;
    end
  endtask

  // nxt: 0 idle, 1 T0, 6 halt
  task automatic execute(input int wait_c, input bit br, input bit hl, input bit rn,
                         input bit rn2, output int nxt);
    in_t i;
    for (int j = 0; j < wait_c; j++) begin
      i = noise(); i.exec_done = 1'b0; emit(i, 1, 4, SNone);
    end
    i = noise();
    i.exec_done = 1'b1; i.branch_taken = br; i.halt_req = hl; i.run = rn;
    emit(i, 1, 4, SNone);
    if (br) begin
      i = noise(); i.run = rn2; emit(i, 1, 5, SBr);
      nxt = hl ? 6 : (rn2 ? 1 : 0);
    end else begin
      nxt = hl ? 6 : (rn ? 1 : 0);
    end
  endtask

  task automatic sit(input int st, input logic [11:0] s, input int k);
    in_t i;
    for (int j = 0; j < k; j++) begin
      i = noise(); emit(i, 1, st, s);
    end
  endtask

  task automatic do_clear(input int k, input bit chk0, input int st0, input logic [11:0] s0);
    in_t i;
    i = noise(); i.clear = 1'b1; emit(i, chk0, st0, s0);
    n_fetch = 0;
    for (int j = 1; j < k; j++) begin
      i = noise(); i.clear = 1'b1; emit(i, 1, 0, SNone);
    end
  endtask

  task automatic build_plan();
    int  nx;
    in_t i;
    do_clear(2, 0, 0, SNone);
    go_idle_to_t0(0);
    fetch(0, 0);
    execute(0, 0, 0, 1, 0, nx);
    fetch(0, 5);
    execute(2, 0, 0, 1, 0, nx);
    fetch(0, MT - 1);
    execute(0, 1, 0, 1, 1, nx);
    fetch(4, 0);
    execute(1, 0, 0, 0, 0, nx);
    go_idle_to_t0(2);
    // clear mid-T1 while mem_ready is high
    i = noise(); i.stall = 1'b0; emit(i, 1, 1, ST0);
    for (int j = 0; j < 3; j++) begin
      i = noise(); i.mem_ready = 1'b0; emit(i, 1, 2, ST1);
    end
    i = noise(); i.clear = 1'b1; i.mem_ready = 1'b1; emit(i, 1, 2, ST1);
    n_fetch = 0;
    go_idle_to_t0(1);
    fetch(0, 1);
    execute(0, 1, 1, 1, 1, nx);
    sit(6, SHalt, 4);
    do_clear(1, 1, 6, SHalt);
    go_idle_to_t0(0);
    fetch(0, MT + 3);
    sit(7, SFault, 3);
    do_clear(2, 1, 7, SFault);
    go_idle_to_t0(0);
    for (int k = 0; k < 320; k++) begin
      int st_c, dl;
      st_c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      dl   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, MT - 1))
                                         : int'($urandom_range(0, 2));
      fetch(st_c, dl);
      execute(int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0), 1'b0,
              ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0), nx);
      if (nx == 0) go_idle_to_t0(int'($urandom_range(0, 2)));
    end
    fetch(0, 0);
    execute(0, 0, 1, 1, 1, nx);
    sit(6, SHalt, 2);
  endtask

  always @(negedge clock) begin : monitor
    exp_t        e;
    logic [11:0] act;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        act = {pc_out, mar_in, pc_enable, pc_inc, target_out, mem_read, mdr_in, mdr_out,
               ir_in, ir_valid, halted, fault};
        n_checks++;
        if (state !== e.st || act !== e.strb || fetch_count !== e.cnt) begin
          n_fail++;
          $display("FAIL cycle-check t=%0t state/strobes/count got %0d/%03h/%0d expected %0d/%03h/%0d",
                   $time, state, act, fetch_count, e.st, e.strb, e.cnt);
        end
      end
    end else if (stuck) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain scoreboard still holds %0d entries, required 0", sb_q.size());
      stuck = 1'b0;
    end
  end

  initial begin
    in_t  cur;
    exp_t e;
    build_plan();
    while (in_q.size() > 0) begin
      @(posedge clock);
      #1;
      cur = in_q.pop_front();
      e   = plan_q.pop_front();
      {clear, run, stall, mem_ready, exec_done, branch_taken, halt_req} = cur;
      sb_q.push_back(e);
    end
    for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(negedge clock);
    if (sb_q.size() > 0) begin
      sb_q.delete();
      stuck = 1'b1;
    end
    repeat (2) @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
